// File: rtl/gen_arb_rr_hold_top.sv
// gen_arb_rr_hold_top: round-robin arbiter with held grants and an optional hold limit.
//
// A grant is held until its owner releases it, drops its request, or has held
// it for MAX_HOLD cycles. On release the priority pointer moves to the slot
// after the holder and the next grant is issued in the same edge, so there is
// no idle cycle between holders.
//
// Parameters:
//   WID      - number of requesters (2..64)
//   MAX_HOLD - maximum consecutive grant cycles; 0 disables the limit
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   rqsts    - per-requester request levels
//   rels     - per-requester release pulses (only the holder's bit is used)
//   grnts    - registered one-hot grant (or zero)
//   grnt_vld - registered, high when grnts is non-zero
//   grnt_idx - registered index of the granted requester, 0 when idle
//   tout     - registered one-cycle pulse after a forced release
module gen_arb_rr_hold_top #(
  parameter int unsigned WID      = 16,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WID-1:0]           rqsts,
  input  logic [WID-1:0]           rels,
  output logic [WID-1:0]           grnts,
  output logic                     grnt_vld,
  output logic [$clog2(WID)-1:0]   grnt_idx,
  output logic                     tout
);

  localparam int unsigned IW  = $clog2(WID);
  localparam int unsigned HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic [IW-1:0] g_next;
  logic [IW-1:0] arb_base;
  logic [IW-1:0] arb_idx;
  logic          arb_hit;
  logic          holder_req;
  logic          forced;
  logic          release_ev;

  // Slot after the current holder: the pointer value after a release.
  always_comb begin
    g_next = '0;
    if (grnt_idx != IW'(WID - 1)) begin
      g_next = grnt_idx + 1'b1;
    end
  end

  always_comb begin
    holder_req = rqsts[grnt_idx];
    forced     = 1'b0;
    if (MAX_HOLD > 0) begin
      // Forced only when no voluntary release coincides with the limit.
      forced = (hold_cnt == HW'(LIM)) && holder_req && !rels[grnt_idx];
    end
    release_ev = rels[grnt_idx] || !holder_req || forced;
  end

  // While busy, arbitrate from the slot after the holder so the outcome is
  // ready in the release cycle; the holder naturally lands at lowest priority.
  always_comb begin
    arb_base = (state == BUSY) ? g_next : ptr;
  end

  always_comb begin
    int unsigned   k;
    logic [IW-1:0] idx_v;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int unsigned i = 0; i < WID; i++) begin
      k = 32'(arb_base) + i;
      if (k >= WID) begin
        k = k - WID;
      end
      idx_v = IW'(k);
      if (!arb_hit && rqsts[idx_v]) begin
        arb_hit = 1'b1;
        arb_idx = idx_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grnts    <= '0;
      grnt_vld <= 1'b0;
      grnt_idx <= '0;
      tout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tout <= 1'b0;
          if (arb_hit) begin
            state    <= BUSY;
            grnts    <= WID'(1) << arb_idx;
            grnt_vld <= 1'b1;
            grnt_idx <= arb_idx;
            hold_cnt <= '0;
          end
        end
        BUSY: begin
          tout <= forced;
          if (release_ev) begin
            ptr      <= g_next;
            hold_cnt <= '0;
            if (arb_hit) begin
              grnts    <= WID'(1) << arb_idx;
              grnt_vld <= 1'b1;
              grnt_idx <= arb_idx;
            end else begin
              state    <= IDLE;
              grnts    <= '0;
              grnt_vld <= 1'b0;
              grnt_idx <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gen_arb_rr_hold_top.md
GEN_ARB_RR_HOLD_TOP -- requirements
Module: gen_arb_rr_hold_top

Interface
REQ-001 SHALL have parameter WID, default 16: number of requesters, allowed range 2..64.
REQ-002 SHALL have parameter MAX_HOLD, default 16: maximum cycles a grant may be held; 0 disables the limit.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port rqsts, input, WID: per-requester request level.
REQ-006 SHALL have port rels, input, WID: per-requester release pulse, meaningful only for the current holder.
REQ-007 SHALL have port grnts, output, WID: registered grant, one-hot or zero.
REQ-008 SHALL have port grnt_vld, output, 1: registered; high iff grnts is non-zero.
REQ-009 SHALL have port grnt_idx, output, max(1,$clog2(WID)): registered index of the granted bit; 0 when grnt_vld is low.
REQ-010 SHALL have port tout, output, 1: registered one-cycle pulse marking a forced release.

Function
REQ-011 SHALL implement a two-state machine: IDLE (no grant) and BUSY (grant held).
REQ-012 SHALL keep a priority pointer ptr in 0..WID-1. ptr is the highest-priority index; priority falls with increasing index modulo WID.
REQ-013 SHALL arbitrate combinationally each cycle: select the first set rqsts bit, searching from ptr with wrap-around.
REQ-014 In IDLE, when any rqsts bit is set, the block SHALL register the selected one-hot grant and enter BUSY. Request-to-grant latency is 1 cycle.
REQ-015 In IDLE with rqsts = 0, the block SHALL remain in IDLE with grnts = 0.
REQ-016 In BUSY, grnts SHALL stay constant until a release event for holder g. Release events are:
  - rels[g] high;
  - rqsts[g] low;
  - forced release, per REQ-019.
REQ-017 On a release event, the block SHALL in that cycle:
  - set ptr to (g+1) mod WID;
  - re-arbitrate from the new ptr, including g at lowest priority if rqsts[g] is still high.
  The new grant SHALL appear next cycle with no idle bubble. If no request is eligible, the block SHALL go to IDLE with grnts = 0.
REQ-018 SHALL ignore rels bits for non-holders, and SHALL ignore all rels bits in IDLE.
REQ-019 SHALL implement hold counter hold_cnt:
  - cleared on each new grant;
  - incremented each BUSY cycle without a release.
  When MAX_HOLD > 0 and hold_cnt reaches MAX_HOLD-1 without another release event, that cycle is a forced release.
REQ-020 SHALL drive tout high in the cycle after a forced release, for 1 cycle. tout SHALL NOT be asserted when rels or a request drop coincides with the limit.
REQ-021 A holder SHALL therefore see at most MAX_HOLD consecutive grant cycles per grant.
REQ-022 A sole requester re-granted after a forced release SHALL have its counter restarted at 0.
REQ-023 SHALL make grnt_idx and grnt_vld consistent with grnts in every cycle.
REQ-024 grnts SHALL never have more than one bit set.
REQ-025 A rqsts change on a non-holder SHALL NOT affect the current grant.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL load:
  - state = IDLE, ptr = 0, hold_cnt = 0;
  - grnts = 0, grnt_vld = 0, grnt_idx = 0, tout = 0.
REQ-027 Reset SHALL override all concurrent requests and releases, including reset asserted mid-grant. The grant SHALL be 0 in the cycle after the reset edge.
REQ-028 The first arbitration after reset SHALL use ptr = 0.

Verification
All scenarios use WID=4, MAX_HOLD=8.
REQ-029 Reset, then rqsts=4'b1010 -> one cycle later grnts=4'b0010, grnt_idx=1, grnt_vld=1.
REQ-030 From REQ-029, with rqsts held at 1010:
  - pulse rels[1] -> next cycle grnts=4'b1000 (no bubble);
  - pulse rels[3] -> grnts=4'b0010 (wrap-around).
REQ-031 Reset, then rqsts=4'b1111 held, rels pulsed by each holder one cycle after its grant -> grant order 0,1,2,3,0.
REQ-032 Only rqsts[2] high, rels never pulsed -> grnts=4'b0100 for exactly 8 cycles, then:
  - tout=1 for one cycle;
  - re-granted next cycle, hold_cnt restarts, next tout 8 cycles later.
REQ-033 Holder 1 drops rqsts[1] with rqsts=0 otherwise -> next cycle grnts=0, grnt_vld=0, state IDLE, tout=0.
REQ-034 rst asserted while grnts=4'b1000 with rqsts=4'b1111 -> next cycle all outputs 0. After rst deasserts, the first grant is 4'b0001.
